// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider (signed/unsigned), one quotient bit per clock plus a sign-fix cycle.
// Optional feature: define DIV_FLUSH_EN to add a flush input that abandons an in-flight operation.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
`ifdef DIV_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             start,
  input  logic             Sign,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state, state_nxt;
  logic             load, step, finish, flush_req;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem, dvd, dsr, in1_raw;
  logic             neg_q, neg_r, dz;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b, rem_sh;
  logic [WIDTH:0]   trial;

`ifdef DIV_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  // Magnitudes only for negative signed operands; -(-2^(W-1)) wraps to 2^(W-1) as unsigned.
  assign a_neg  = Sign & in1[WIDTH-1];
  assign b_neg  = Sign & in2[WIDTH-1];
  assign mag_a  = a_neg ? -in1 : in1;
  assign mag_b  = b_neg ? -in2 : in2;

  assign rem_sh = {rem[WIDTH-2:0], dvd[WIDTH-1]};
  assign trial  = {rem, dvd[WIDTH-1]} - {1'b0, dsr};

  assign busy   = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !flush_req) begin
          load      = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (flush_req) begin
          state_nxt = IDLE;
        end else begin
          step = 1'b1;
          if (count == CW'(1)) state_nxt = FIX;
        end
      end
      FIX: begin
        state_nxt = IDLE;
        finish    = !flush_req;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too; they are few and it keeps outputs defined after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      rem       <= '0;
      dvd       <= '0;
      dsr       <= '0;
      in1_raw   <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      dz        <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        count   <= CW'(WIDTH);
        rem     <= '0;
        dvd     <= mag_a;
        dsr     <= mag_b;
        in1_raw <= in1;
        neg_q   <= a_neg ^ b_neg;
        neg_r   <= a_neg;
        dz      <= (in2 == '0);
      end else if (step) begin
        // dvd doubles as the quotient shift register: dividend bits leave at the top, quotient bits enter at the bottom.
        rem   <= trial[WIDTH] ? rem_sh : trial[WIDTH-1:0];
        dvd   <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
        count <= count - CW'(1);
      end
      if (finish) begin
        div_zero <= dz;
        if (dz) begin
          quotient  <= '1;
          remainder <= in1_raw;
        end else begin
          quotient  <= neg_q ? -dvd : dvd;
          remainder <= neg_r ? -rem : rem;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit (WIDTH=32): directed corner cases plus randomized operands
// compared against an arithmetic reference model.
module tb_div_unit;

  localparam int W       = 32;
  localparam int LATENCY = W + 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic         Sign;
  logic [W-1:0] in1, in2;
  logic         busy, done, div_zero;
  logic [W-1:0] quotient, remainder;
`ifdef DIV_FLUSH_EN
  logic         flush = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
`ifdef DIV_FLUSH_EN
    .flush    (flush),
`endif
    .start    (start),
    .Sign     (Sign),
    .in1      (in1),
    .in2      (in2),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else             n_pass++;
  endtask

  // Reference: plain SV arithmetic (truncating division) plus the divide-by-zero and overflow rules.
  function automatic void ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    dz = (b == '0);
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = '0;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end
  endfunction

  // Called #1 after an edge; returns #1 after the edge that accepted the start (E0).
  task automatic launch(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1;
    Sign  = s;
    in1   = a;
    in2   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Waits for done (bounded), checks latency and results. inject_at>0 pulses a junk start mid-op.
  task automatic finish_op(input string tag, input logic s, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int inject_at);
    logic [W-1:0] eq, er;
    logic         edz;
    int           edges;
    ref_div(s, a, b, eq, er, edz);
    check({tag, "_busy"}, W'(busy), W'(1));
    edges = 1;
    while (edges < LATENCY + 8) begin
      if (edges == inject_at) begin
        start = 1'b1;
        Sign  = ~s;
        in1   = $urandom;
        in2   = $urandom;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      edges++;
      if (done) break;
    end
    check({tag, "_lat"}, W'(edges), W'(LATENCY));
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dz"}, W'(div_zero), W'(edz));
    check({tag, "_idle"}, W'(busy), W'(0));
  endtask

  task automatic run_op(input string tag, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    launch(s, a, b);
    finish_op(tag, s, a, b, 0);
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, W'(done), W'(0));
  endtask

  initial begin
    logic [W-1:0] ra, rb, q_hold, r_hold;
    logic         rs;

    reset_n = 1'b0;
    start   = 1'b0;
    Sign    = 1'b0;
    in1     = '0;
    in2     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", W'(busy), W'(0));
    check("rst_done", W'(done), W'(0));
    check("rst_q", quotient, '0);
    check("rst_r", remainder, '0);
    check("rst_dz", W'(div_zero), W'(0));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    run_op("u100_7", 1'b0, 32'd100, 32'd7);
    run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    run_op("u_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2);
    run_op("divzero", 1'b0, 32'h1234_5678, 32'd0);
    run_op("s_divzero", 1'b1, 32'h8765_4321, 32'd0);
    run_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("s_min_1", 1'b1, 32'h8000_0000, 32'd1);
    run_op("u_max_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);

    // Start pulsed mid-CALC must not disturb the in-flight op.
    launch(1'b0, 32'd1000, 32'd33);
    finish_op("inject", 1'b0, 32'd1000, 32'd33, 5);

    // Back-to-back: start driven during the done cycle.
    launch(1'b1, 32'hFFFF_FC18, 32'd7);
    finish_op("b2b_1", 1'b1, 32'hFFFF_FC18, 32'd7, 0);
    launch(1'b0, 32'd99, 32'd10);
    finish_op("b2b_2", 1'b0, 32'd99, 32'd10, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 20; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(1, 15));
        1:       rb = $urandom >> $urandom_range(0, 31);
        2:       rb = (i % 5 == 0) ? 32'd0 : $urandom;
        default: rb = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), rs, ra, rb);
    end

`ifdef DIV_FLUSH_EN
    q_hold = quotient;
    r_hold = remainder;
    launch(1'b0, 32'd500, 32'd3);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", W'(busy), W'(0));
    begin
      logic seen;
      seen = 1'b0;
      repeat (LATENCY + 2) begin
        @(posedge clk);
        #1;
        seen |= done;
      end
      check("flush_nodone", W'(seen), W'(0));
    end
    check("flush_q", quotient, q_hold);
    check("flush_r", remainder, r_hold);
`else
    q_hold = '0;
    r_hold = '0;
`endif

    // Reset in CALC cycle 10 abandons the op immediately.
    launch(1'b0, 32'd12345, 32'd11);
    repeat (9) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("midrst_busy", W'(busy), W'(0));
    check("midrst_done", W'(done), W'(0));
    check("midrst_q", quotient, q_hold & '0);
    check("midrst_r", remainder, r_hold & '0);
    @(negedge clk);
    reset_n = 1'b1;
    begin
      logic seen;
      seen = 1'b0;
      repeat (LATENCY + 2) begin
        @(posedge clk);
        #1;
        seen |= done;
      end
      check("midrst_nodone", W'(seen), W'(0));
    end

    run_op("after_rst", 1'b1, 32'hFFFF_FF9C, 32'd7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
